// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) helpers for the iterative cipher core.
package aes_pkg;

    localparam int NR      = 10;
    localparam int BLOCK_W = 128;
    localparam int KEY_W   = BLOCK_W * (NR + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } aes_state_e;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_state,
    input  logic [BLOCK_W-1:0] i_round_key,
    input  logic               i_last,
    output logic [BLOCK_W-1:0] o_state
);

    logic [7:0] sub_s   [16];
    logic [7:0] shift_s [16];
    logic [7:0] mix_s   [16];

    // SubBytes on every byte of the incoming state
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            sub_s[k] = sbox(i_state[BLOCK_W-1-8*k -: 8]);
        end
    end

    // ShiftRows: row r of column c comes from column (c+r) mod 4
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_s[4*c+r] = sub_s[4*((c+r)%4)+r];
            end
        end
    end

    // MixColumns with matrix rows [02 03 01 01] and rotations
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mix_s[4*c+0] = xtime(shift_s[4*c+0]) ^ xtime(shift_s[4*c+1]) ^ shift_s[4*c+1]
                         ^ shift_s[4*c+2] ^ shift_s[4*c+3];
            mix_s[4*c+1] = shift_s[4*c+0] ^ xtime(shift_s[4*c+1]) ^ xtime(shift_s[4*c+2])
                         ^ shift_s[4*c+2] ^ shift_s[4*c+3];
            mix_s[4*c+2] = shift_s[4*c+0] ^ shift_s[4*c+1] ^ xtime(shift_s[4*c+2])
                         ^ xtime(shift_s[4*c+3]) ^ shift_s[4*c+3];
            mix_s[4*c+3] = xtime(shift_s[4*c+0]) ^ shift_s[4*c+0] ^ shift_s[4*c+1]
                         ^ shift_s[4*c+2] ^ xtime(shift_s[4*c+3]);
        end
    end

    // AddRoundKey; the final round bypasses MixColumns
    always_comb begin
        o_state = {BLOCK_W{1'b0}};
        for (int k = 0; k < 16; k++) begin
            if (i_last) begin
                o_state[BLOCK_W-1-8*k -: 8] = shift_s[k] ^ i_round_key[BLOCK_W-1-8*k -: 8];
            end else begin
                o_state[BLOCK_W-1-8*k -: 8] = mix_s[k] ^ i_round_key[BLOCK_W-1-8*k -: 8];
            end
        end
    end

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption core: one round per clock, 11-cycle block throughput.
module aes_cipher_core #(
    parameter int NR    = aes_pkg::NR,
    parameter int KEY_W = aes_pkg::BLOCK_W * (NR + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [aes_pkg::BLOCK_W-1:0] i_plaintext,
    input  logic [KEY_W-1:0]            i_expanded_key,
    output logic                        o_ready,
    output logic                        o_valid,
    output logic [aes_pkg::BLOCK_W-1:0] o_ciphertext
);

    localparam int             BW         = aes_pkg::BLOCK_W;
    localparam logic [3:0]     LAST_ROUND = 4'(NR);

    aes_pkg::aes_state_e fsm_q;
    logic [BW-1:0]       state_q;
    logic [BW-1:0]       ciphertext_q;
    logic [KEY_W-1:0]    key_q;
    logic [3:0]          round_q;
    logic                valid_q;
    logic [BW-1:0]       round_key_s;
    logic [BW-1:0]       round_out_s;
    logic                last_s;

    // Pick the round key for the current round from the captured schedule
    always_comb begin
        round_key_s = key_q[KEY_W-1-BW*int'(round_q) -: BW];
        last_s      = (round_q == LAST_ROUND);
    end

    aes_round u_round (
        .i_state     (state_q),
        .i_round_key (round_key_s),
        .i_last      (last_s),
        .o_state     (round_out_s)
    );

    // Control FSM together with the datapath registers and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fsm_q        <= aes_pkg::IDLE;
            round_q      <= 4'd0;
            state_q      <= {BW{1'b0}};
            key_q        <= {KEY_W{1'b0}};
            ciphertext_q <= {BW{1'b0}};
            valid_q      <= 1'b0;
        end else begin
            case (fsm_q)
                aes_pkg::IDLE: begin
                    valid_q <= 1'b0;
                    if (i_start) begin
                        key_q   <= i_expanded_key;
                        state_q <= i_plaintext ^ i_expanded_key[KEY_W-1 -: BW];
                        round_q <= 4'd1;
                        fsm_q   <= aes_pkg::RUN;
                    end else begin
                        fsm_q   <= aes_pkg::IDLE;
                    end
                end
                aes_pkg::RUN: begin
                    if (last_s) begin
                        ciphertext_q <= round_out_s;
                        valid_q      <= 1'b1;
                        round_q      <= 4'd0;
                        fsm_q        <= aes_pkg::IDLE;
                    end else begin
                        state_q      <= round_out_s;
                        round_q      <= round_q + 4'd1;
                        valid_q      <= 1'b0;
                    end
                end
                default: begin
                    fsm_q   <= aes_pkg::IDLE;
                    round_q <= 4'd0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready      = (fsm_q == aes_pkg::IDLE);
    assign o_valid      = valid_q;
    assign o_ciphertext = ciphertext_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Randomised self-checking bench for aes_cipher_core against a byte-level AES reference model.
module tb_aes_cipher_core;

    localparam int KW = 1408;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic           i_start;
    logic [127:0]   i_plaintext;
    logic [KW-1:0]  i_expanded_key;
    logic           o_ready;
    logic           o_valid;
    logic [127:0]   o_ciphertext;

    int             checks = 0;
    int             errors = 0;
    logic [7:0]     sbox_t [256];
    logic [127:0]   last_ct;

    aes_cipher_core dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_plaintext    (i_plaintext),
        .i_expanded_key (i_expanded_key),
        .o_ready        (o_ready),
        .o_valid        (o_valid),
        .o_ciphertext   (o_ciphertext)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    function automatic logic [7:0] sbox_entry(input int v);
        logic [7:0] inv;
        inv = 8'h00;
        for (int x = 1; x < 256; x++) begin
            if (gmul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [KW-1:0] expand_key(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [KW-1:0] ek;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                    ^ {rcon, 24'h000000};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ek[KW-1-32*i -: 32] = w[i];
        return ek;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [KW-1:0] ek);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ ek[KW-1-8*k -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) t[k] = sbox_t[s[k]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = t[4*((c+row)%4)+row];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ ek[KW-1-128*r-8*k -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    // mode 0: plain request, 1: inputs zeroed after the start edge, 2: extra start pulse at round 5
    task automatic do_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                            input logic [127:0] exp, input int mode);
        int   lat;
        int   busy;
        int   extra;
        bit   seen;
        i_plaintext    = pt;
        i_expanded_key = expand_key(key);
        i_start        = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        if (mode == 1) begin
            i_plaintext    = '0;
            i_expanded_key = '0;
        end
        lat = 0; busy = 0; seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (!o_ready) busy++;
            if (mode == 2 && k == 5) begin
                i_start     = 1'b1;
                i_plaintext = ~pt;
            end else if (mode == 2 && k == 6) begin
                i_start = 1'b0;
            end
            @(posedge i_clk); #1;
            if (o_valid) begin
                seen = 1'b1;
                lat  = k;
                check({tag, "_ct"}, o_ciphertext, exp);
            end
        end
        i_start = 1'b0;
        check({tag, "_latency"}, 128'(lat), 128'd10);
        check({tag, "_busy"}, 128'(busy), 128'd10);
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge i_clk); #1;
            if (o_valid) extra++;
        end
        check({tag, "_extra_valid"}, 128'(extra), 128'd0);
        last_ct = exp;
    endtask

    task automatic back_to_back();
        int           nval;
        int           busy;
        int           v0;
        int           v1;
        logic [127:0] ct0;
        logic [127:0] ct1;
        i_plaintext    = PT_B;
        i_expanded_key = expand_key(KEY_B);
        i_start        = 1'b1;
        @(posedge i_clk); #1;
        i_plaintext    = PT_C;
        i_expanded_key = expand_key(KEY_C);
        nval = 0; busy = 0; v0 = -1; v1 = -1; ct0 = '0; ct1 = '0;
        for (int k = 1; k <= 30; k++) begin
            if (!o_ready) busy++;
            @(posedge i_clk); #1;
            if (o_valid) begin
                if (nval == 0) begin
                    v0 = k; ct0 = o_ciphertext;
                end else if (nval == 1) begin
                    v1 = k; ct1 = o_ciphertext; i_start = 1'b0;
                end
                nval++;
            end
        end
        i_start = 1'b0;
        check("b2b_count", 128'(nval), 128'd2);
        check("b2b_first_edge", 128'(v0), 128'd10);
        check("b2b_second_edge", 128'(v1), 128'd21);
        check("b2b_ct_b", ct0, CT_B);
        check("b2b_ct_c", ct1, CT_C);
        check("b2b_busy", 128'(busy), 128'd20);
        last_ct = CT_C;
    endtask

    task automatic reset_mid_op();
        int nval;
        nval           = 0;
        i_plaintext    = PT_B;
        i_expanded_key = expand_key(KEY_B);
        i_start        = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge i_clk); #1;
            if (o_valid) nval++;
        end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check("rst_mid_ready", 128'(o_ready), 128'd1);
        check("rst_mid_ct", o_ciphertext, 128'd0);
        for (int k = 0; k < 15; k++) begin
            if (o_valid) nval++;
            @(posedge i_clk); #1;
        end
        check("rst_mid_no_valid", 128'(nval), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [127:0] rk;
        logic [127:0] rp;
        for (int v = 0; v < 256; v++) sbox_t[v] = sbox_entry(v);
        i_rst          = 1'b1;
        i_start        = 1'b0;
        i_plaintext    = '0;
        i_expanded_key = '0;
        last_ct        = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_ready", 128'(o_ready), 128'd1);
        check("reset_valid", 128'(o_valid), 128'd0);
        check("reset_ct", o_ciphertext, 128'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        do_block("fips_b", KEY_B, PT_B, CT_B, 0);
        do_block("fips_c1", KEY_C, PT_C, CT_C, 0);
        back_to_back();
        do_block("busy_ignore", KEY_B, PT_B, CT_B, 2);
        do_block("unstable_in", KEY_B, PT_B, CT_B, 1);

        for (int i = 0; i < 6; i++) begin
            rk = {$urandom(), $urandom(), $urandom(), $urandom()};
            rp = {$urandom(), $urandom(), $urandom(), $urandom()};
            do_block($sformatf("rand%0d", i), rk, rp, encrypt(rp, expand_key(rk)), i % 3);
        end

        reset_mid_op();
        do_block("rst_fresh_b", KEY_B, PT_B, CT_B, 0);

        repeat (5) @(posedge i_clk);
        #1;
        check("ct_hold", o_ciphertext, last_ct);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_cipher_core.md
# aes_cipher_core

Iterative AES-128 encryption core that sits directly downstream of the combinational key expansion stage. It consumes the 1408-bit expanded key schedule (11 round keys) plus one 128-bit plaintext block per request. It runs one cipher round per clock and returns the 128-bit ciphertext with a one-cycle valid pulse. Throughput is one block per 11 cycles.

## Interface

Parameters:
- NR, 10, number of cipher rounds (fixed for AES-128; not meant to be overridden)
- KEY_W, 1408, expanded key width = 128*(NR+1)

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_start  input  1  request; accepted on a rising edge where i_start && o_ready
- i_plaintext  input  128  input block; byte 0 is at [127:120]
- i_expanded_key  input  KEY_W  key schedule; round key r is at [KEY_W-1-128*r -: 128], so round key 0 is [1407:1280]
- o_ready  output  1  core can accept a request this cycle
- o_valid  output  1  one-cycle pulse; o_ciphertext is new this cycle
- o_ciphertext  output  128  result block; same byte order as the input

## Operation

- FSM has two states: IDLE and RUN.
- Registers: state_q (128), key_q (KEY_W), round_q (4 bits, 0..10), o_ciphertext, o_valid.
- o_ready = (FSM == IDLE). It is combinational from the FSM register.
- IDLE with start accepted:
  - key_q <= i_expanded_key; the input bus need not stay stable afterwards.
  - state_q <= i_plaintext ^ rk0.
  - round_q <= 1; go to RUN.
- IDLE without start: hold all registers; o_valid <= 0.
- RUN with round_q in 1..9: state_q <= MixColumns(ShiftRows(SubBytes(state_q))) ^ rk[round_q]; round_q++.
- RUN with round_q == 10:
  - o_ciphertext <= ShiftRows(SubBytes(state_q)) ^ rk10. There is no MixColumns in this round.
  - o_valid <= 1; round_q <= 0; go to IDLE.
- i_start is ignored while in RUN. It is never queued.
- o_ciphertext holds its value until the next completion.
- GF(2^8) arithmetic:
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0).
  - MixColumns uses the column matrix [02 03 01 01] with its rotations.
  - The state is column-major: column c = bytes 4c..4c+3.

## Timing

- Reset (i_rst high at an edge): FSM=IDLE, round_q=0, state_q=0, key_q=0, o_ciphertext=0, o_valid=0. o_ready=1 on the cycle after reset.
- Reset during RUN aborts the block. No o_valid is produced, and the partial result never reaches o_ciphertext.
- Latency: if the start is accepted at edge E0, o_valid is high in the cycle after edge E10. That is 10 edges, or 11 cycles from request to result including the request cycle.
- o_valid is high for exactly one cycle.
- o_ready is already high in the o_valid cycle. A start in that cycle is accepted, giving back-to-back blocks every 11 cycles.
- i_start held high continuously produces one block per 11 cycles, with no lost or duplicated results.
- i_rst and i_start both high at the same edge: reset wins and the request is dropped.

## Structure

- Package aes_pkg holds:
  - the 256-entry S-box as a function sbox(byte)
  - xtime()
  - constants NR=10, BLOCK_W=128, KEY_W=1408
  - the state/round enum (IDLE, RUN)
- Sub-module aes_round (combinational):
  - Inputs: 128-bit state, 128-bit round key, flag i_last.
  - Applies SubBytes, then ShiftRows, then MixColumns (skipped when i_last), then AddRoundKey.
  - aes_cipher_core instantiates it once, with round key selected by round_q from key_q.
  - It is separately unit-testable.
- The key expansion stage is not instantiated inside this core. Its output connects to i_expanded_key at the top level.

## Test plan

- FIPS-197 App. B:
  - Key 2b7e151628aed2a6abf7158809cf4f3c, expanded by the key expansion stage; plaintext 3243f6a8885a308d313198a2e0370734.
  - Required: ciphertext 3925841d02dc09fbdc118597196a0b32, with o_valid exactly 10 edges after the start edge.
- FIPS-197 App. C.1:
  - Key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff.
  - Required: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-to-back:
  - i_start held high with App. B then C.1 vectors.
  - Required: two o_valid pulses 11 cycles apart with the correct ciphertexts. o_ready is low for the 10 RUN cycles of each block.
- Busy ignore:
  - Pulse i_start with a different plaintext at round 5.
  - Required: no effect; a single o_valid with the original ciphertext.
- Reset mid-op:
  - Assert i_rst at round 6.
  - Required: o_valid never pulses; o_ciphertext=0; o_ready=1 on the next cycle. A fresh App. B request afterwards yields the correct result.
- Input instability:
  - Change i_expanded_key and i_plaintext to all-zero one cycle after the start.
  - Required: result still equals the App. B ciphertext.
